// File: rtl/csa_pkg.sv
// Shared constants, FSM encoding and group-constant helper for the
// control-word key scheduler.
package csa_pkg;
  localparam int CW_W   = 64;
  localparam int ROUNDS = 7;
  localparam int KK_W   = CW_W * ROUNDS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    COMMIT = 2'd2
  } kst_e;

  // Byte value g replicated across a 64-bit key group.
  function automatic logic [CW_W-1:0] grp_const(input logic [7:0] g);
    return {8{g}};
  endfunction
endpackage

// File: rtl/cw_key_ctrl_key_perm.sv
// Single key-schedule round: a fixed 64-bit bit permutation (bijective
// since 29 is odd), so all-zeros and all-ones words are fixed points.
module key_perm (
  input  logic [63:0] i_d,
  output logic [63:0] o_d
);
  for (genvar i = 0; i < 64; i++) begin : g_bit
    assign o_d[i] = i_d[(i * 29 + 11) % 64];
  end
endmodule

// File: rtl/cw_key_ctrl.sv
// Sequential CW key scheduler: one key_perm stage iterated over ROUNDS
// cycles into a shadow register, then committed into an even/odd bank.
module cw_key_ctrl
  import csa_pkg::*;
#(
  parameter int ROUNDS_P = ROUNDS,
  parameter int CW_W_P   = CW_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CW_W_P-1:0]            i_ck,
  input  logic                         i_ck_valid,
  input  logic                         i_ck_parity,
  output logic                         o_ck_ready,
  input  logic                         i_sel_parity,
  output logic [ROUNDS_P*CW_W_P-1:0]   o_kk,
  output logic                         o_kk_valid,
  output logic                         o_busy
);
  typedef logic [ROUNDS_P-1:0][CW_W_P-1:0] key_t;

  kst_e              state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [CW_W_P-1:0] work_q, work_d;
  logic              par_q, par_d;
  key_t              shadow_q, shadow_d;
  key_t [1:0]        bank_q, bank_d;
  logic [1:0]        valid_q, valid_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;

  logic [CW_W_P-1:0] perm_out;
  logic [2:0]        gidx;

  key_perm u_key_perm (
    .i_d (work_q),
    .o_d (perm_out)
  );

  // Groups are filled from the top down: round 0 lands in group ROUNDS-1.
  assign gidx = 3'(ROUNDS_P - 1) - cnt_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    par_d    = par_q;
    shadow_d = shadow_q;
    bank_d   = bank_q;
    valid_d  = valid_q;
    ready_d  = ready_q;
    busy_d   = busy_q;
    case (state_q)
      IDLE: begin
        if (i_ck_valid) begin
          work_d  = i_ck;
          par_d   = i_ck_parity;
          cnt_d   = 3'd0;
          state_d = EXPAND;
          ready_d = 1'b0;
          busy_d  = 1'b1;
        end
      end
      EXPAND: begin
        shadow_d[gidx] = work_q ^ grp_const({5'd0, gidx});
        work_d         = perm_out;
        cnt_d          = cnt_q + 3'd1;
        if (cnt_q == 3'(ROUNDS_P - 1)) state_d = COMMIT;
      end
      COMMIT: begin
        // Only here does a bank change, so no partial key is ever visible.
        bank_d[par_q]  = shadow_q;
        valid_d[par_q] = 1'b1;
        state_d        = IDLE;
        ready_d        = 1'b1;
        busy_d         = 1'b0;
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      work_q   <= '0;
      par_q    <= 1'b0;
      shadow_q <= '0;
      bank_q   <= '0;
      valid_q  <= 2'b00;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      par_q    <= par_d;
      shadow_q <= shadow_d;
      bank_q   <= bank_d;
      valid_q  <= valid_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  assign o_ck_ready = ready_q;
  assign o_busy     = busy_q;
  assign o_kk       = bank_q[i_sel_parity];
  assign o_kk_valid = valid_q[i_sel_parity];
endmodule

// File: tb/tb_cw_key_ctrl.sv
// Randomized bench for cw_key_ctrl against a transaction-level model:
// accepted CW -> fully expanded key committed exactly 8 cycles later.
module tb_cw_key_ctrl;
  logic         clk = 1'b0;
  logic         rst;
  logic [63:0]  i_ck;
  logic         i_ck_valid;
  logic         i_ck_parity;
  logic         o_ck_ready;
  logic         i_sel_parity;
  logic [447:0] o_kk;
  logic         o_kk_valid;
  logic         o_busy;

  cw_key_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .i_ck         (i_ck),
    .i_ck_valid   (i_ck_valid),
    .i_ck_parity  (i_ck_parity),
    .o_ck_ready   (o_ck_ready),
    .i_sel_parity (i_sel_parity),
    .o_kk         (o_kk),
    .o_kk_valid   (o_kk_valid),
    .o_busy       (o_busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  int cyc = 0, prev_acc = -1, n_acc = 0, n_com = 0;
  bit in_stream = 0, last_acc = 0;

  logic [447:0] m_bank [2];
  logic [1:0]   m_valid;
  logic [447:0] m_key;
  logic         m_par;
  bit           m_pend;
  int           m_cnt;

  task automatic chk(input string tag, input logic [447:0] got, input logic [447:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  // Reference round: output bit i takes input bit (29i+11) mod 64.
  function automatic logic [63:0] perm(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[i] = x[(i * 29 + 11) % 64];
    return y;
  endfunction

  function automatic logic [447:0] expand(input logic [63:0] cw);
    logic [447:0] r;
    logic [63:0]  w;
    logic [7:0]   b;
    w = cw;
    for (int k = 0; k < 7; k++) begin
      b = 8'(6 - k);
      r[(6 - k) * 64 +: 64] = w ^ {8{b}};
      w = perm(w);
    end
    return r;
  endfunction

  task automatic chk_outs();
    chk("ready", 448'(o_ck_ready), 448'(!m_pend));
    chk("busy", 448'(o_busy), 448'(m_pend));
    chk("kk", o_kk, m_bank[i_sel_parity]);
    chk("kk_valid", 448'(o_kk_valid), 448'(m_valid[i_sel_parity]));
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare.
  task automatic step();
    bit acc;
    acc = rst && i_ck_valid && !m_pend;
    @(posedge clk);
    #1;
    cyc++;
    last_acc = acc;
    if (!rst) begin
      m_pend = 0;
      m_valid = 2'b00;
      m_bank[0] = '0;
      m_bank[1] = '0;
    end else begin
      if (m_pend) begin
        m_cnt++;
        if (m_cnt == 8) begin
          m_bank[m_par] = m_key;
          m_valid[m_par] = 1'b1;
          m_pend = 0;
          n_com++;
        end
      end
      if (acc) begin
        m_pend = 1;
        m_cnt = 0;
        m_key = expand(i_ck);
        m_par = i_ck_parity;
        n_acc++;
        if (in_stream && prev_acc >= 0) chk("acc_gap", 448'(cyc - prev_acc), 448'(9));
        prev_acc = cyc;
      end
    end
    chk_outs();
  endtask

  task automatic load(input logic [63:0] cw, input logic par);
    i_ck = cw;
    i_ck_parity = par;
    i_ck_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (last_acc) break;
    end
    if (!last_acc) chk("accept_timeout", 448'(0), 448'(1));
    i_ck_valid = 1'b0;
    repeat (8) step();
  endtask

  logic [447:0] zero_key;

  initial begin
    rst = 1'b0;
    i_ck = '0;
    i_ck_valid = 1'b0;
    i_ck_parity = 1'b0;
    i_sel_parity = 1'b0;
    m_pend = 0;
    m_valid = 2'b00;
    m_bank[0] = '0;
    m_bank[1] = '0;
    for (int g = 0; g < 7; g++) zero_key[g * 64 +: 64] = {8{8'(g)}};

    repeat (2) step();
    rst = 1'b1;
    step();

    // Abort the very first load at cnt=3.
    i_ck = {$urandom, $urandom};
    i_ck_valid = 1'b1;
    step();
    chk("abort_accepted", 448'(last_acc), 448'(1));
    i_ck_valid = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("abort_ready", 448'(o_ck_ready), 448'(1));
    chk("abort_busy", 448'(o_busy), 448'(0));
    chk("abort_kk0", o_kk, 448'(0));
    chk("abort_v0", 448'(o_kk_valid), 448'(0));
    i_sel_parity = 1'b1;
    #1;
    chk("abort_kk1", o_kk, 448'(0));
    chk("abort_v1", 448'(o_kk_valid), 448'(0));
    i_sel_parity = 1'b0;
    step();

    // All-zero CW into the even bank.
    load(64'h0, 1'b0);
    chk("zero_g6", 448'(o_kk[6*64 +: 64]), 448'(64'h0606060606060606));
    chk("zero_g0", 448'(o_kk[0 +: 64]), 448'(0));
    chk("zero_key", o_kk, zero_key);
    chk("zero_valid", 448'(o_kk_valid), 448'(1));
    i_sel_parity = 1'b1;
    #1;
    chk("odd_empty_v", 448'(o_kk_valid), 448'(0));
    chk("odd_empty_kk", o_kk, 448'(0));

    // All-ones CW into the odd bank.
    load(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    chk("ones_g5", 448'(o_kk[5*64 +: 64]), 448'(64'hFAFAFAFAFAFAFAFA));
    chk("ones_key", o_kk, ~zero_key);
    i_sel_parity = 1'b0;
    #1;
    chk("even_kept", o_kk, zero_key);

    // Random even loads; the second overwrites while selected.
    i_sel_parity = 1'b0;
    load({$urandom, $urandom}, 1'b0);
    load({$urandom, $urandom}, 1'b0);
    i_sel_parity = 1'b1;
    load({$urandom, $urandom}, 1'b1);

    // Continuous valid, alternating parity, random select each cycle.
    n_acc = 0;
    n_com = 0;
    prev_acc = -1;
    in_stream = 1;
    i_ck = {$urandom, $urandom};
    i_ck_parity = 1'b0;
    i_ck_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      i_sel_parity = 1'($urandom);
      step();
      if (last_acc) begin
        i_ck = {$urandom, $urandom};
        i_ck_parity = ~i_ck_parity;
      end
    end
    i_ck_valid = 1'b0;
    in_stream = 0;
    repeat (10) begin
      i_sel_parity = 1'($urandom);
      step();
    end
    chk("stream_acc_count", 448'(n_acc), 448'(12));
    chk("acc_vs_commit", 448'(n_com), 448'(n_acc));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/cw_key_ctrl.md
Name: cw_key_ctrl

Overview:
Sequential control-word key scheduler for the descrambler core. It accepts 64-bit control words (CW) through a valid/ready handshake, tagged even or odd. It expands each CW into the 56-byte round key by iterating a single key_perm stage over 7 cycles, instead of a 7-deep combinational chain. It double-buffers the even and odd expanded keys so the block-cipher datapath can switch parity per packet without stalling.

Parameters:
ROUNDS, 7, number of key_perm iterations / 64-bit key groups produced (fixed by the algorithm; other values unsupported)
CW_W, 64, control-word width in bits

Ports:
clk  input  1  single clock, all logic rising-edge
rst  input  1  reset, synchronous, active-low
i_ck  input  64  control word to load
i_ck_valid  input  1  i_ck/i_ck_parity valid
i_ck_parity  input  1  target bank: 0 = even, 1 = odd
o_ck_ready  output  1  block can accept a CW this cycle
i_sel_parity  input  1  bank presented on o_kk
o_kk  output  448  expanded key of selected bank, group g at bits [64g+63:64g]
o_kk_valid  output  1  selected bank holds a committed key
o_busy  output  1  expansion in progress

Behaviour:
- Reset (rst=0 at a clk edge):
  - FSM -> IDLE; round counter = 0.
  - Work register, shadow, and both banks = 0; both bank-valid flags = 0.
  - Outputs after reset: o_ck_ready=1, o_busy=0, o_kk=0, o_kk_valid=0.
  - Reset mid-expansion aborts it: no bank is updated or validated.
- FSM states: IDLE, EXPAND, COMMIT.
- IDLE:
  - o_ck_ready=1.
  - On i_ck_valid&&o_ck_ready at edge T: work <= i_ck, par_q <= i_ck_parity, cnt <= 0 -> EXPAND.
  - i_ck_valid while not ready is ignored; the source must hold it.
- EXPAND (edges T+1..T+7, cnt = 0..6):
  - shadow group (6-cnt) <= work ^ {8{byte(6-cnt)}}, i.e. constant 0x0606..06 for group 6 down to 0x0000..00 for group 0.
  - work <= key_perm(work); cnt <= cnt+1.
  - At cnt=6 -> COMMIT.
  - o_busy=1, o_ck_ready=0.
- COMMIT (edge T+8):
  - bank[par_q] <= shadow; valid[par_q] <= 1 -> IDLE.
  - o_busy=1, o_ck_ready=0.
- Latency and throughput:
  - Key visible on o_kk the cycle after edge T+8, i.e. 8 cycles after acceptance.
  - Next CW accepted at the earliest on edge T+9.
  - Throughput: one CW per 9 cycles.
- Banks and selection:
  - The bank being reloaded keeps its old contents and valid flag until COMMIT; no partial key is ever exposed.
  - The other bank is never disturbed.
  - o_kk = bank[i_sel_parity] and o_kk_valid = valid[i_sel_parity], both combinational from registers.
  - i_sel_parity may change every cycle.
- Simultaneous events:
  - i_sel_parity == par_q at COMMIT: the new key appears the following cycle; the old key is presented up to and including the commit cycle.
  - Reloading the same parity back-to-back is legal; the later commit overwrites.
- Width rule: all XORs are bytewise over 64-bit groups; no carries, no arithmetic.

Decomposition:
- Shared package (csa_pkg):
  - CW_W=64, ROUNDS=7, KK_W=448.
  - FSM state encoding (IDLE=2'd0, EXPAND=2'd1, COMMIT=2'd2).
  - Function returning the group constant {8{g[7:0]}}.
- Sub-module: a single instance of the existing key_perm (64-bit in/out, combinational), fed by the work register.
- Everything else (FSM, counter, shadow, banks, output mux) stays in cw_key_ctrl.

Test Plan:
- Reset, then load i_ck=64'h0 parity 0:
  - o_ck_ready drops for 8 cycles.
  - Then with sel=0: o_kk group g = {8{8'hg}}, e.g. group 6 = 64'h0606060606060606 and group 0 = 0; o_kk_valid=1.
  - With sel=1: o_kk_valid=0, o_kk=0.
- Load i_ck=64'hFFFFFFFFFFFFFFFF parity 1:
  - sel=1 gives group g = {8{8'hFF^g}}, e.g. group 5 = 64'hFAFAFAFAFAFAFAFA.
  - Even bank from the previous test is unchanged.
- Load a random CW, even:
  - o_kk must match the reference model: group (6-k) = perm^k(CW) ^ {8{6-k}}.
  - Acceptance-to-valid latency is exactly 8 cycles.
- Reload even bank while sel=0:
  - The old key stays on o_kk through the commit cycle; the new key appears next cycle.
  - o_kk_valid never drops.
- Assert rst=0 at cnt=3 during the first-ever load:
  - Next cycle: o_ck_ready=1, o_busy=0, both valid flags 0, o_kk=0.
- Hold i_ck_valid=1 continuously with alternating parity:
  - Exactly one acceptance per 9 cycles.
  - No CW lost or duplicated (bench counts handshakes against commits).
